// File: rtl/card_dealer_pkg.sv
// Shared types, sizes and card-index helpers for the card dealer.
package card_dealer_pkg;

    localparam int unsigned NUM_RANKS  = 13;
    localparam int unsigned DECK_SIZE  = 52;
    localparam int unsigned CARD_IDX_W = 6;
    localparam int unsigned SUIT_W     = 2;
    localparam int unsigned RANK_W     = 4;
    localparam int unsigned COUNT_W    = 6;

    localparam logic [SUIT_W-1:0] SUIT_DIAMOND = 2'd0;
    localparam logic [SUIT_W-1:0] SUIT_CLUB    = 2'd1;
    localparam logic [SUIT_W-1:0] SUIT_HEART   = 2'd2;
    localparam logic [SUIT_W-1:0] SUIT_SPADE   = 2'd3;

    // State encoding
    localparam logic [1:0] ST_IDLE_ENC = 2'd0;
    localparam logic [1:0] ST_DRAW_ENC = 2'd1;
    localparam logic [1:0] ST_SCAN_ENC = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE_ENC,
        DRAW = ST_DRAW_ENC,
        SCAN = ST_SCAN_ENC
    } state_e;

    typedef struct packed {
        logic [SUIT_W-1:0] suit;
        logic [RANK_W-1:0] rank;
    } card_t;

    // Rank 1..13 is a real card; 0, 14 and 15 are RNG garbage.
    function automatic logic rank_valid(input logic [RANK_W-1:0] rank);
        return (rank >= RANK_W'(1)) && (rank <= RANK_W'(NUM_RANKS));
    endfunction

    // idx = suit*13 + (rank-1); only meaningful when rank_valid(rank).
    function automatic logic [CARD_IDX_W-1:0] card_idx(input logic [SUIT_W-1:0] suit,
                                                       input logic [RANK_W-1:0] rank);
        return CARD_IDX_W'(suit) * CARD_IDX_W'(NUM_RANKS) + CARD_IDX_W'(rank) - CARD_IDX_W'(1);
    endfunction

    // Inverse of card_idx for idx 0..51.
    function automatic card_t idx_to_card(input logic [CARD_IDX_W-1:0] idx);
        card_t c;
        c.suit = SUIT_W'(idx / CARD_IDX_W'(NUM_RANKS));
        c.rank = RANK_W'(idx % CARD_IDX_W'(NUM_RANKS)) + RANK_W'(1);
        return c;
    endfunction

endpackage

// File: rtl/card_dealer_if.sv
// Deal handshake between the game FSM (master) and the card dealer (slave).
//  deal_req   master->slave  request one card
//  deal_ready slave->master  dealer idle, request will be accepted
//  card_valid slave->master  one-cycle pulse, card_suit/card_rank valid
//  card_suit  slave->master  suit of last dealt card
//  card_rank  slave->master  rank of last dealt card
//  deal_err   slave->master  one-cycle pulse, request hit an empty deck
interface card_dealer_if;
    logic                               deal_req;
    logic                               deal_ready;
    logic                               card_valid;
    logic [card_dealer_pkg::SUIT_W-1:0] card_suit;
    logic [card_dealer_pkg::RANK_W-1:0] card_rank;
    logic                               deal_err;

    modport master (
        output deal_req,
        input  deal_ready, card_valid, card_suit, card_rank, deal_err
    );

    modport slave (
        input  deal_req,
        output deal_ready, card_valid, card_suit, card_rank, deal_err
    );
endinterface

// File: rtl/card_dealer_deck_bitmap.sv
// Used-card bitmap with undealt-card counter.
//  clk, rst_n    clock, synchronous active-low reset
//  clear         new deck: every card free again
//  set, set_idx  mark card set_idx as dealt
//  query_idx     card to test; query_used_c is its used bit (out-of-range reads as used)
//  cards_left    undealt cards 0..52
//  deck_empty    registered cards_left==0
module card_dealer_deck_bitmap
    import card_dealer_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  set,
    input  logic [CARD_IDX_W-1:0] set_idx,
    input  logic [CARD_IDX_W-1:0] query_idx,
    output logic                  query_used_c,
    output logic [COUNT_W-1:0]    cards_left,
    output logic                  deck_empty
);

    logic [DECK_SIZE-1:0] used;

    // Indices 52..63 do not exist, so never report them as free.
    always_comb begin
        query_used_c = 1'b1;
        if (query_idx < CARD_IDX_W'(DECK_SIZE)) begin
            query_used_c = used[query_idx];
        end
    end

    // Bitmap and counter move together so cards_left always equals the free-bit count.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            used       <= '0;
            cards_left <= COUNT_W'(DECK_SIZE);
            deck_empty <= 1'b0;
        end else if (set && (set_idx < CARD_IDX_W'(DECK_SIZE)) && !used[set_idx]
                     && (cards_left != '0)) begin
            used[set_idx] <= 1'b1;
            cards_left    <= cards_left - COUNT_W'(1);
            deck_empty    <= (cards_left == COUNT_W'(1));
        end
    end

endmodule

// File: rtl/card_dealer.sv
// Deals unique cards from one 52-card deck using free-running suit/rank RNGs.
// Random draws are tried MAX_RETRY times, then a wrap-around scan guarantees completion.
//  clk, rst_n         clock, synchronous active-low reset
//  new_deck           clear deck and abort any in-flight deal
//  rng_suit, rng_rank RNG outputs sampled every DRAW cycle
//  bus                deal handshake (slave side)
//  cards_left         undealt cards 0..52
//  deck_empty         registered cards_left==0
module card_dealer
    import card_dealer_pkg::*;
#(
    parameter int unsigned MAX_RETRY = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               new_deck,
    input  logic [SUIT_W-1:0]  rng_suit,
    input  logic [RANK_W-1:0]  rng_rank,
    card_dealer_if.slave       bus,
    output logic [COUNT_W-1:0] cards_left,
    output logic               deck_empty
);

    localparam int unsigned RETRY_W = (MAX_RETRY > 1) ? $clog2(MAX_RETRY) : 1;

    state_e                state;
    logic [RETRY_W-1:0]    retry;
    logic [CARD_IDX_W-1:0] scan_idx;
    card_t                 card_q;
    logic                  card_valid_q;
    logic                  deal_err_q;

    logic                  draw_valid_c;
    logic [CARD_IDX_W-1:0] draw_idx_c;
    logic [CARD_IDX_W-1:0] query_idx_c;
    logic                  query_used_c;
    logic                  hit_c;
    logic                  issue_c;

    // Candidate card for this cycle: RNG in DRAW, scan pointer in SCAN.
    always_comb begin
        draw_valid_c = rank_valid(rng_rank);
        draw_idx_c   = card_idx(rng_suit, rng_rank);
        query_idx_c  = (state == SCAN) ? scan_idx : draw_idx_c;
        hit_c        = 1'b0;
        if (state == DRAW) begin
            hit_c = draw_valid_c && !query_used_c;
        end else if (state == SCAN) begin
            hit_c = !query_used_c;
        end
        // new_deck wins: the card is dropped and never marked used.
        issue_c = hit_c && !new_deck;
    end

    card_dealer_deck_bitmap u_bitmap (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear        (new_deck),
        .set          (issue_c),
        .set_idx      (query_idx_c),
        .query_idx    (query_idx_c),
        .query_used_c (query_used_c),
        .cards_left   (cards_left),
        .deck_empty   (deck_empty)
    );

    // Deal FSM with registered card, valid and error outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            retry        <= '0;
            scan_idx     <= '0;
            card_q       <= '0;
            card_valid_q <= 1'b0;
            deal_err_q   <= 1'b0;
        end else begin
            card_valid_q <= 1'b0;
            deal_err_q   <= 1'b0;
            if (new_deck) begin
                state <= IDLE;
                retry <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.deal_req) begin
                            if (deck_empty) begin
                                deal_err_q <= 1'b1;
                            end else begin
                                state <= DRAW;
                                retry <= '0;
                            end
                        end
                    end
                    DRAW: begin
                        if (hit_c) begin
                            card_q       <= '{suit: rng_suit, rank: rng_rank};
                            card_valid_q <= 1'b1;
                            state        <= IDLE;
                        end else if (retry == RETRY_W'(MAX_RETRY - 1)) begin
                            // Out of random attempts; scan from the last draw if it named a card.
                            state    <= SCAN;
                            scan_idx <= draw_valid_c ? draw_idx_c : '0;
                        end else begin
                            retry <= retry + RETRY_W'(1);
                        end
                    end
                    SCAN: begin
                        if (hit_c) begin
                            card_q       <= idx_to_card(scan_idx);
                            card_valid_q <= 1'b1;
                            state        <= IDLE;
                        end else if (scan_idx == CARD_IDX_W'(DECK_SIZE - 1)) begin
                            scan_idx <= '0;
                        end else begin
                            scan_idx <= scan_idx + CARD_IDX_W'(1);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.deal_ready = (state == IDLE);
    assign bus.card_valid = card_valid_q;
    assign bus.card_suit  = card_q.suit;
    assign bus.card_rank  = card_q.rank;
    assign bus.deal_err   = deal_err_q;

endmodule
